lsu_wb_data_port: RTL and testbench

//  Data-side load/store unit: accepts one load/store per request from the MEM stage, runs
//  a classic Wishbone single cycle on the data bus, aligns byte/half/word data both ways.

---
 rtl/lsu_wb_data_port.sv | 190 +++++++++++++++++++
 tb/tb_lsu_wb_data_port.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_wb_data_port.sv
// Data-side load/store port: one MEM-stage request becomes one classic Wishbone cycle,
// with byte/half/word lane steering on stores and extraction/extension on loads.
// state | meaning
// IDLE  | ready for a request; response pulse for the previous access appears here
// WAIT  | bus cycle outstanding, waiting for ack/err or timeout
// FAULT | misaligned/illegal request, report on the next edge without touching the bus
module lsu_wb_data_port #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_misalign_o,
    output logic              rsp_buserr_o,
    output logic              rsp_timeout_o,
    output logic [ADDR_W-1:0] rsp_badaddr_o,
    output logic              lsu_stall_o,
    input  logic [31:0]       ddat_i,
    input  logic              dack_i,
    input  logic              derr_i,
    output logic [ADDR_W-1:0] daddr_o,
    output logic [31:0]       ddat_o,
    output logic [3:0]        dsel_o,
    output logic              dcyc_o,
    output logic              dstb_o,
    output logic              dwe_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_uns;

    logic              w_misalign;
    logic [3:0]        w_sel;
    logic [31:0]       w_wdat;
    logic [31:0]       w_shift;
    logic [31:0]       w_rdata;
    logic              w_tout;

    always_comb begin
        w_misalign = 1'b0;
        w_sel      = 4'b1111;
        w_wdat     = req_wdata_i;
        case (req_size_i)
            2'd0: begin
                w_sel  = 4'b0001 << req_addr_i[1:0];
                w_wdat = {4{req_wdata_i[7:0]}};
            end
            2'd1: begin
                w_misalign = req_addr_i[0];
                w_sel      = 4'b0011 << req_addr_i[1:0];
                w_wdat     = {2{req_wdata_i[15:0]}};
            end
            2'd2: w_misalign = |req_addr_i[1:0];
            default: w_misalign = 1'b1;
        endcase
    end

    // Load path works from the captured request, since req_* may change during WAIT.
    always_comb begin
        w_shift = ddat_i >> {r_addr[1:0], 3'b000};
        w_rdata = w_shift;
        case (r_size)
            2'd0:    w_rdata = {{24{w_shift[7] & ~r_uns}}, w_shift[7:0]};
            2'd1:    w_rdata = {{16{w_shift[15] & ~r_uns}}, w_shift[15:0]};
            default: w_rdata = w_shift;
        endcase
    end

    assign w_tout = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_addr         <= '0;
            r_we           <= 1'b0;
            r_size         <= 2'd0;
            r_uns          <= 1'b0;
            req_ready_o    <= 1'b0;
            rsp_valid_o    <= 1'b0;
            rsp_rdata_o    <= '0;
            rsp_misalign_o <= 1'b0;
            rsp_buserr_o   <= 1'b0;
            rsp_timeout_o  <= 1'b0;
            rsp_badaddr_o  <= '0;
            lsu_stall_o    <= 1'b0;
            daddr_o        <= '0;
            ddat_o         <= '0;
            dsel_o         <= 4'd0;
            dcyc_o         <= 1'b0;
            dstb_o         <= 1'b0;
            dwe_o          <= 1'b0;
        end else begin
            rsp_valid_o    <= 1'b0;
            rsp_rdata_o    <= '0;
            rsp_misalign_o <= 1'b0;
            rsp_buserr_o   <= 1'b0;
            rsp_timeout_o  <= 1'b0;
            rsp_badaddr_o  <= '0;
            case (r_state)
                S_IDLE: begin
                    if (req_ready_o && req_valid_i) begin
                        r_addr      <= req_addr_i;
                        r_we        <= req_we_i;
                        r_size      <= req_size_i;
                        r_uns       <= req_unsigned_i;
                        r_cnt       <= '0;
                        req_ready_o <= 1'b0;
                        lsu_stall_o <= 1'b1;
                        if (w_misalign) begin
                            r_state <= S_FAULT;
                        end else begin
                            r_state <= S_WAIT;
                            dcyc_o  <= 1'b1;
                            dstb_o  <= 1'b1;
                            dwe_o   <= req_we_i;
                            daddr_o <= {req_addr_i[ADDR_W-1:2], 2'b00};
                            dsel_o  <= w_sel;
                            ddat_o  <= w_wdat;
                        end
                    end else begin
                        req_ready_o <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (derr_i || dack_i || w_tout) begin
                        r_state     <= S_IDLE;
                        req_ready_o <= 1'b1;
                        lsu_stall_o <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        dcyc_o      <= 1'b0;
                        dstb_o      <= 1'b0;
                        dwe_o       <= 1'b0;
                        daddr_o     <= '0;
                        dsel_o      <= 4'd0;
                        ddat_o      <= '0;
                        // Error wins over a simultaneous ack; timeout only when neither arrived.
                        if (derr_i) begin
                            rsp_buserr_o  <= 1'b1;
                            rsp_badaddr_o <= r_addr;
                        end else if (dack_i) begin
                            if (!r_we) rsp_rdata_o <= w_rdata;
                        end else begin
                            rsp_timeout_o <= 1'b1;
                            rsp_badaddr_o <= r_addr;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FAULT: begin
                    r_state        <= S_IDLE;
                    req_ready_o    <= 1'b1;
                    lsu_stall_o    <= 1'b0;
                    rsp_valid_o    <= 1'b1;
                    rsp_misalign_o <= 1'b1;
                    rsp_badaddr_o  <= r_addr;
                end
                default: begin
                    r_state     <= S_IDLE;
                    req_ready_o <= 1'b1;
                    lsu_stall_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_wb_data_port.sv
// Scoreboard bench for lsu_wb_data_port: directed cases plus randomized loads/stores
// against an arithmetic reference model of alignment, lane steering and extension.
module tb_lsu_wb_data_port;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [1:0]  req_size_i = 2'd0;
    logic        req_unsigned_i = 1'b0;
    logic [31:0] req_addr_i = '0;
    logic [31:0] req_wdata_i = '0;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_misalign_o;
    logic        rsp_buserr_o;
    logic        rsp_timeout_o;
    logic [31:0] rsp_badaddr_o;
    logic        lsu_stall_o;
    logic [31:0] ddat_i = '0;
    logic        dack_i = 1'b0;
    logic        derr_i = 1'b0;
    logic [31:0] daddr_o;
    logic [31:0] ddat_o;
    logic [3:0]  dsel_o;
    logic        dcyc_o;
    logic        dstb_o;
    logic        dwe_o;

    always #5 clk = ~clk;

    lsu_wb_data_port #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
        .rsp_misalign_o(rsp_misalign_o), .rsp_buserr_o(rsp_buserr_o),
        .rsp_timeout_o(rsp_timeout_o), .rsp_badaddr_o(rsp_badaddr_o),
        .lsu_stall_o(lsu_stall_o), .ddat_i(ddat_i), .dack_i(dack_i), .derr_i(derr_i),
        .daddr_o(daddr_o), .ddat_o(ddat_o), .dsel_o(dsel_o), .dcyc_o(dcyc_o),
        .dstb_o(dstb_o), .dwe_o(dwe_o)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        berr;
        logic        tout;
        logic [31:0] bad;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ld_model(input logic [31:0] d, input int k, input int sz, input bit uns);
        int n;
        logic [63:0] m;
        logic [31:0] v;
        n = 1 << sz;
        m = (64'h1 << (8 * n)) - 64'h1;
        v = (d >> (8 * k)) & m[31:0];
        if (!uns && v[8*n-1]) v = v | ~m[31:0];
        return v;
    endfunction

    function automatic logic [3:0] sel_model(input int k, input int sz);
        int n;
        logic [3:0] s;
        n = 1 << sz;
        s = 4'd0;
        for (int i = 0; i < 4; i++) if (i >= k && i < k + n) s[i] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] wdat_model(input logic [31:0] w, input int sz);
        int n;
        logic [31:0] o;
        n = 1 << sz;
        o = '0;
        for (int i = 0; i < 4; i++) o[8*i +: 8] = w[8*(i % n) +: 8];
        return o;
    endfunction

    exp_t got;
    always @(negedge clk) begin
        if (!rst) begin
            if (rsp_valid_o) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    got = sb.pop_front();
                    chk("rsp_rdata", rsp_rdata_o, got.rdata);
                    chk("rsp_misalign", {31'd0, rsp_misalign_o}, {31'd0, got.mis});
                    chk("rsp_buserr", {31'd0, rsp_buserr_o}, {31'd0, got.berr});
                    chk("rsp_timeout", {31'd0, rsp_timeout_o}, {31'd0, got.tout});
                    chk("rsp_badaddr", rsp_badaddr_o, got.bad);
                end
            end else begin
                chk("rsp_idle_zero", rsp_rdata_o | rsp_badaddr_o |
                    {29'd0, rsp_misalign_o, rsp_buserr_o, rsp_timeout_o}, 32'd0);
            end
        end
    end

    // Called at a falling edge; returns at the falling edge where the unit is ready.
    task automatic wait_ready();
        int n = 0;
        while (!req_ready_o && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready_o) chk("ready_wait_expired", 32'd0, 32'd1);
    endtask

    // mode: 0 ack, 1 err, 2 err+ack together, 3 no reply (timeout)
    task automatic run_txn(input bit we, input int sz, input bit uns, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] ddat,
                           input int lat, input int mode);
        int   k;
        bit   mis;
        int   n;
        exp_t e;
        k   = int'(addr % 4);
        mis = (sz == 3) || ((addr % (1 << sz)) != 0);
        wait_ready();
        req_valid_i    = 1'b1;
        req_we_i       = we;
        req_size_i     = 2'(sz);
        req_unsigned_i = uns;
        req_addr_i     = addr;
        req_wdata_i    = wdata;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        req_addr_i  = $urandom;
        req_wdata_i = $urandom;
        e.rdata = '0; e.mis = 1'b0; e.berr = 1'b0; e.tout = 1'b0; e.bad = '0;
        if (mis) begin
            e.mis = 1'b1; e.bad = addr;
        end else if (mode == 0) begin
            e.rdata = we ? 32'd0 : ld_model(ddat, k, sz, uns);
        end else if (mode == 3) begin
            e.tout = 1'b1; e.bad = addr;
        end else begin
            e.berr = 1'b1; e.bad = addr;
        end
        sb.push_back(e);
        @(negedge clk);
        if (mis) begin
            chk("no_bus_on_misalign", {31'd0, dcyc_o}, 32'd0);
            @(negedge clk);
        end else begin
            chk("dcyc", {31'd0, dcyc_o}, 32'd1);
            chk("dstb", {31'd0, dstb_o}, 32'd1);
            chk("dwe", {31'd0, dwe_o}, {31'd0, we});
            chk("daddr", daddr_o, addr & 32'hFFFF_FFFC);
            chk("dsel", {28'd0, dsel_o}, {28'd0, sel_model(k, sz)});
            chk("ddat_o", ddat_o, wdat_model(wdata, sz));
            if (mode == 3) begin
                n = 0;
                while (dcyc_o && n < 4 * TO) begin
                    @(negedge clk);
                    n++;
                end
                chk("timeout_wait_cycles", n, TO);
            end else begin
                repeat (lat) @(negedge clk);
                dack_i = (mode != 1);
                derr_i = (mode != 0);
                ddat_i = ddat;
                @(posedge clk);
                #1 dack_i = 1'b0;
                derr_i = 1'b0;
                ddat_i = $urandom;
                @(negedge clk);
                chk("bus_released", {31'd0, dcyc_o | dstb_o}, 32'd0);
            end
        end
        chk("rsp_timing", {31'd0, rsp_valid_o}, 32'd1);
    endtask

    initial begin
        #2;
        chk("rst_ready", {31'd0, req_ready_o}, 32'd0);
        chk("rst_bus", {28'd0, dsel_o} | {31'd0, dcyc_o | dstb_o | dwe_o} | daddr_o | ddat_o, 32'd0);
        chk("rst_rsp", {31'd0, rsp_valid_o | lsu_stall_o}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_txn(0, 2, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
        run_txn(0, 0, 0, 32'h103, 32'h0, 32'h80FF0000, 0, 0);
        run_txn(0, 0, 1, 32'h103, 32'h0, 32'h80FF0000, 1, 0);
        run_txn(1, 1, 0, 32'h202, 32'h1234ABCD, 32'h55555555, 2, 0);
        run_txn(0, 2, 0, 32'h105, 32'h0, 32'h0, 0, 0);
        run_txn(1, 3, 0, 32'h200, 32'hFFFF, 32'h0, 0, 0);
        run_txn(0, 1, 0, 32'h301, 32'h0, 32'h0, 0, 0);
        run_txn(0, 2, 0, 32'h300, 32'h0, 32'h0, 0, 3);
        run_txn(0, 2, 0, 32'h304, 32'h0, 32'h1, 1, 2);
        run_txn(1, 0, 0, 32'h305, 32'hA5, 32'h0, 0, 1);
        run_txn(0, 1, 0, 32'h306, 32'h0, 32'h8001_7777, TO - 1, 0);

        // Abort mid-WAIT with reset: bus drops at once, no response is produced.
        wait_ready();
        req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'd2; req_addr_i = 32'h40;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        @(negedge clk);
        chk("pre_rst_dcyc", {31'd0, dcyc_o}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_dcyc_dstb", {30'd0, dcyc_o, dstb_o}, 32'd0);
        chk("async_rst_rsp", {31'd0, rsp_valid_o}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_txn(0, 0, 1, 32'h41, 32'h0, 32'h0000_C300, 0, 0);

        for (int t = 0; t < 150; t++) begin
            logic [31:0] a;
            int sz;
            int r;
            sz = ($urandom % 8 == 0) ? 3 : int'($urandom % 3);
            a  = $urandom;
            if ($urandom % 2 == 0) a[1:0] = 2'b00;
            r  = int'($urandom % 10);
            run_txn(1'($urandom % 2), sz, 1'($urandom % 2), a, $urandom, $urandom,
                    int'($urandom % TO), (r < 7) ? 0 : (r == 7) ? 1 : (r == 8) ? 2 : 3);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
